// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mm_pkg
//  Purpose : Shared constants and FSM state type for the 2x2 matrix stream
//            loader and its neighbouring multiplier.
//  Contents: DW      - default element width in bits
//            MM_N    - elements per 2x2 matrix
//            MM_OPN  - operand elements per set (A and B)
//            state_t - loader FSM states
//  Revision: 1.0 - initial release
// ============================================================================
package mm_pkg;

  localparam int DW     = 8;
  localparam int MM_N   = 4;
  localparam int MM_OPN = 2 * MM_N;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,  // collecting operand bytes
    ST_WAIT = 2'd1,  // operands stable, waiting out multiplier latency
    ST_EMIT = 2'd2   // streaming the four results
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mat_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module  : mat_stream_loader
//  Purpose : Deserialises an 8-element operand stream (A11..A22, B11..B22)
//            into registers that drive an external 2x2 multiplier, waits
//            MM_LATENCY edges, captures the four results and serialises them
//            back out with valid/ready handshaking. One set in flight at a
//            time.
//  Ports   : clk, rst             - clock, async active-high reset
//            in_data/valid/ready  - operand stream in
//            mm_a, mm_b           - operand arrays to the multiplier
//            mm_c                 - result array from the multiplier
//            out_data/valid/ready - result stream out
//            busy                 - high while waiting or emitting
//  Revision: 1.0 - initial release
// ============================================================================
module mat_stream_loader #(
  parameter int DW         = mm_pkg::DW,
  parameter int MM_LATENCY = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DW-1:0]                       in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [mm_pkg::MM_N-1:0][DW-1:0]     mm_a,
  output logic [mm_pkg::MM_N-1:0][DW-1:0]     mm_b,
  input  logic [mm_pkg::MM_N-1:0][DW-1:0]     mm_c,
  output logic [DW-1:0]                       out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  import mm_pkg::*;

  // Counter must be able to hold MM_LATENCY itself.
  localparam int            WCW       = (MM_LATENCY < 1) ? 1 : $clog2(MM_LATENCY + 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(MM_LATENCY);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [2:0]                   r_idx;
  logic [WCW-1:0]               r_wait_cnt;
  logic [1:0]                   r_oidx;
  logic [MM_OPN-1:0][DW-1:0]    r_opnd;
  logic [MM_N-1:0][DW-1:0]      r_res;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_wait_done;

  assign in_ready    = (r_state == ST_LOAD);
  assign out_valid   = (r_state == ST_EMIT);
  assign busy        = (r_state != ST_LOAD);
  assign w_in_xfer   = in_valid && in_ready;
  assign w_out_xfer  = out_valid && out_ready;
  assign w_wait_done = (r_state == ST_WAIT) && (r_wait_cnt == WCNT_LAST);

  // Operand registers feed the multiplier directly; they only change in LOAD,
  // so they are stable for the whole WAIT/EMIT window.
  assign mm_a     = r_opnd[MM_N-1:0];
  assign mm_b     = r_opnd[MM_OPN-1:MM_N];
  assign out_data = r_res[r_oidx];

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD: if (w_in_xfer && (r_idx == 3'd7))    w_next_state = ST_WAIT;
      ST_WAIT: if (w_wait_done)                      w_next_state = ST_EMIT;
      ST_EMIT: if (w_out_xfer && (r_oidx == 2'd3))   w_next_state = ST_LOAD;
      default:                                       w_next_state = ST_LOAD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, latency counter, result capture, output index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= 3'd0;
      r_wait_cnt <= '0;
      r_oidx     <= 2'd0;
      r_opnd     <= '0;
      r_res      <= '0;
    end else begin
      if (w_in_xfer) begin
        r_opnd[r_idx] <= in_data;
        if (r_idx == 3'd7) begin
          r_idx      <= 3'd0;
          r_wait_cnt <= '0;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end

      if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      if (w_wait_done) begin
        r_res <= mm_c;
      end

      // 2-bit index wraps from 3 back to 0 on the final transfer.
      if (w_out_xfer) begin
        r_oidx <= r_oidx + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mat_stream_loader.md
MAT_STREAM_LOADER -- requirements
Module: mat_stream_loader

Interface
REQ-001 Parameter DW, default 8, element width in bits.
REQ-002 Parameter MM_LATENCY, default 3, clock edges from stable operands to valid C at the 2x2 multiplier output.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_data  input  DW  operand byte stream; order A0,A1,A2,A3,B0,B1,B2,B3 (row-major, A11 first).
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 mm_a  output  DW x4  operand A array to the multiplier (A11,A12,A21,A22).
REQ-009 mm_b  output  DW x4  operand B array to the multiplier (B11,B12,B21,B22).
REQ-010 mm_c  input  DW x4  result array from the multiplier (C11,C12,C21,C22).
REQ-011 out_data  output  DW  result stream; order C0,C1,C2,C3.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 busy  output  1  high in WAIT and EMIT.

Function
REQ-015 FSM states SHALL be LOAD, WAIT and EMIT; LOAD is the reset state.
REQ-016 in_ready SHALL be 1 in LOAD only; a transfer occurs on an edge with in_valid && in_ready.
REQ-017 In LOAD, each transfer SHALL write in_data to operand slot idx (0-3 to mm_a[idx], 4-7 to mm_b[idx-4]) and increment idx (3 bits).
REQ-018 The transfer with idx==7 SHALL set idx to 0, clear wait_cnt, and enter WAIT.
REQ-019 in_valid while in_ready==0 SHALL be ignored; in_data SHALL NOT be sampled then.
REQ-020 mm_a/mm_b SHALL be driven directly from the operand registers and SHALL hold stable in WAIT and EMIT.
REQ-021 In WAIT, wait_cnt SHALL increment each cycle; on the edge where wait_cnt==MM_LATENCY, mm_c[0..3] SHALL be captured into result registers and the FSM SHALL enter EMIT (capture on the 4th edge after the last operand edge for MM_LATENCY=3).
REQ-022 In EMIT, out_valid SHALL be 1 and out_data SHALL equal result[oidx]; oidx SHALL advance only on out_valid && out_ready.
REQ-023 out_data SHALL hold stable while out_valid==1 and out_ready==0.
REQ-024 The transfer with oidx==3 SHALL clear oidx, drop out_valid, and return to LOAD; in_ready SHALL be 1 on the following cycle.
REQ-025 No arithmetic SHALL be performed; results pass unmodified (the multiplier supplies the truncated low DW bits).
REQ-026 The FSM SHALL accept one operand set at a time; no new operands SHALL be accepted until all 4 results are transferred.

Reset
REQ-027 rst SHALL asynchronously force state=LOAD, idx=0, wait_cnt=0, oidx=0, and all operand and result registers to 0.
REQ-028 During reset, outputs SHALL be in_ready=1, out_valid=0, busy=0, out_data=0, mm_a=mm_b=0.
REQ-029 Reset asserted mid-LOAD, mid-WAIT or mid-EMIT SHALL discard the partial set; after release the next accepted byte SHALL be A0.

Structure
REQ-030 Package mm_pkg SHALL hold DW, element count MM_N=4, operand count 2*MM_N, and the state enum.
REQ-031 The block SHALL contain no sub-module; the 2x2 multiplier SHALL be instantiated beside it by the parent and connected via mm_a/mm_b/mm_c.

Verification
REQ-032 Connect the bench to the real multiplier. Stream A={1,2,3,4}, B={5,6,7,8} with out_ready=1. Required: out stream 19,22,43,50; busy high from the edge after the 8th byte until the last result transfers.
REQ-033 Stream A={200,200,200,200}, B={200,200,200,200}. Required: every output 128 (80000 mod 256).
REQ-034 Apply in_valid with a random 50% duty and out_ready low for 5 cycles mid-EMIT. Required: same results; out_data stable while stalled; in_ready=0 throughout WAIT and EMIT.
REQ-035 Assert rst after 5 bytes, then stream a full set A={1,0,0,1}, B={9,8,7,6}. Required: output 9,8,7,6.
REQ-036 Send two back-to-back sets with in_valid held high. Required: the 9th byte is not accepted until the cycle after C3 transfers; both result sets are correct.
